gpio_port: RTL and testbench

- Parametrised memory-mapped GPIO port replacing the fixed 8-bit LED/PMOD output ports in the SoC.
- Each pin has output data, per-pin direction and per-pin output polarity inversion, so negative-logic RGB LEDs need no external inverters.
- Inputs are synchronised, readable and can raise edge-triggered interrupts.
- Sits on the SoC peripheral bus; one instance per physical port (PMOD A, PMOD B, RGB LED).

---
 rtl/gpio_port.sv | 111 +++++++++++
 tb/tb_gpio_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: per-pin data, direction and pad inversion,
// synchronised inputs with edge-triggered W1C interrupt status.
module gpio_port #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '1,
  parameter logic [WIDTH-1:0] INVERT_MASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rd_valid,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  localparam logic [3:0] A_OUT  = 4'd0;
  localparam logic [3:0] A_DIR  = 4'd1;
  localparam logic [3:0] A_IN   = 4'd2;
  localparam logic [3:0] A_SET  = 4'd3;
  localparam logic [3:0] A_CLR  = 4'd4;
  localparam logic [3:0] A_TGL  = 4'd5;
  localparam logic [3:0] A_REN  = 4'd6;
  localparam logic [3:0] A_FEN  = 4'd7;
  localparam logic [3:0] A_STAT = 4'd8;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] w1c;

  assign pin_out = out_q ^ INVERT_MASK;
  assign pin_oe  = dir_q;
  assign irq     = |stat_q;

  assign edge_ev = (sync2 & ~prev & rise_en)
                 | (~sync2 & prev & fall_en);
  assign w1c = (wr_en && addr == A_STAT) ? wdata : '0;

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_OUT:   rd_mux = out_q;
      A_DIR:   rd_mux = dir_q;
      A_IN:    rd_mux = sync2;
      A_REN:   rd_mux = rise_en;
      A_FEN:   rd_mux = fall_en;
      A_STAT:  rd_mux = stat_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= RESET_OUT;
      dir_q   <= RESET_DIR;
      rise_en <= '0;
      fall_en <= '0;
    end else if (wr_en) begin
      case (addr)
        A_OUT:   out_q   <= wdata;
        A_DIR:   dir_q   <= wdata;
        A_SET:   out_q   <= out_q | wdata;
        A_CLR:   out_q   <= out_q & ~wdata;
        A_TGL:   out_q   <= out_q ^ wdata;
        A_REN:   rise_en <= wdata;
        A_FEN:   fall_en <= wdata;
        default: ;
      endcase
    end
  end

  // A new edge event on a bit overrides a same-cycle W1C of that bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      stat_q <= '0;
    end else begin
      sync1  <= pin_in;
      sync2  <= sync1;
      prev   <= sync2;
      stat_q <= (stat_q & ~w1c) | edge_ev;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: directed steps then random traffic checked
// against a register-level model kept here.
module tb_gpio_port;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] addr;
  logic       wr_en, rd_en;
  logic [7:0] wdata, rdata, pin_in, pin_out, pin_oe;
  logic       rd_valid, irq;

  logic [3:0] addr3;
  logic       wr3, rd3;
  logic [2:0] wdata3, rdata3, pin_in3, pin_out3, pin_oe3;
  logic       rd_valid3, irq3;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_out, m_dir, m_ren, m_fen, m_stat, m_rdata;
  logic       m_rv;
  logic [7:0] s0, s1, s2;

  always #5 clk = ~clk;

  gpio_port u8 (
    .clk(clk), .reset_n(reset_n), .addr(addr),
    .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
    .rdata(rdata), .rd_valid(rd_valid), .pin_in(pin_in),
    .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  gpio_port #(
    .WIDTH(3), .RESET_OUT(3'h0), .RESET_DIR(3'h7),
    .INVERT_MASK(3'h7)
  ) u3 (
    .clk(clk), .reset_n(reset_n), .addr(addr3),
    .wr_en(wr3), .rd_en(rd3), .wdata(wdata3),
    .rdata(rdata3), .rd_valid(rd_valid3), .pin_in(pin_in3),
    .pin_out(pin_out3), .pin_oe(pin_oe3), .irq(irq3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 8'h00; m_dir = 8'hFF;
    m_ren = 0; m_fen = 0; m_stat = 0;
    m_rdata = 0; m_rv = 0;
    s0 = 0; s1 = 0; s2 = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] a);
    case (a)
      0: return m_out;
      1: return m_dir;
      2: return s1;
      6: return m_ren;
      7: return m_fen;
      8: return m_stat;
      default: return 8'h00;
    endcase
  endfunction

  // s0..s2 are the pad values sampled at the last three edges
  task automatic model_edge(input bit w, input bit r,
                            input logic [3:0] a, input logic [7:0] d,
                            input logic [7:0] p);
    logic [7:0] ev;
    ev = (s1 & ~s2 & m_ren) | (~s1 & s2 & m_fen);
    if (r) m_rdata = m_read(a);
    m_rv = r;
    if (w) begin
      case (a)
        0: m_out = d;
        1: m_dir = d;
        3: m_out = m_out | d;
        4: m_out = m_out & ~d;
        5: m_out = m_out ^ d;
        6: m_ren = d;
        7: m_fen = d;
        8: m_stat = m_stat & ~d;
        default: ;
      endcase
    end
    m_stat = m_stat | ev;
    s2 = s1; s1 = s0; s0 = p;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pin_out"}, pin_out, m_out);
    chk({tag, ".pin_oe"}, pin_oe, m_dir);
    chk({tag, ".irq"}, irq, |m_stat);
    chk({tag, ".rd_valid"}, rd_valid, m_rv);
    chk({tag, ".rdata"}, rdata, m_rdata);
  endtask

  task automatic cyc(input bit w, input bit r, input logic [3:0] a,
                     input logic [7:0] d, input logic [7:0] p,
                     input string tag);
    wr_en = w; rd_en = r; addr = a; wdata = d; pin_in = p;
    @(posedge clk);
    model_edge(w, r, a, d, p);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset_n = 0;
    wr_en = 0; rd_en = 0; addr = 0; wdata = 0; pin_in = 0;
    wr3 = 0; rd3 = 0; addr3 = 0; wdata3 = 0; pin_in3 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pin_out", pin_out, 8'h00);
    chk("rst.pin_oe", pin_oe, 8'hFF);
    chk("rst.irq", irq, 1'b0);
    chk("rst.w3_pin_out", pin_out3, 3'h7);
    check_all("rst");
    @(negedge clk);
    reset_n = 1;

    cyc(1'b0, 1'b1, 4'd0, 8'h00, 8'h00, "rd0");
    chk("rd0.valid", rd_valid, 1'b1);
    chk("rd0.data", rdata, 8'h00);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, "rd0_drop");

    wr3 = 1; wdata3 = 3'h1;
    cyc(1'b1, 1'b0, 4'd0, 8'hA5, 8'h00, "wr_out");
    wr3 = 0;
    chk("w3.pin_out", pin_out3, 3'h6);
    chk("seq.a5", pin_out, 8'hA5);
    cyc(1'b1, 1'b0, 4'd3, 8'h0F, 8'h00, "set");
    chk("seq.af", pin_out, 8'hAF);
    cyc(1'b1, 1'b0, 4'd4, 8'h80, 8'h00, "clr");
    chk("seq.2f", pin_out, 8'h2F);
    cyc(1'b1, 1'b0, 4'd5, 8'h03, 8'h00, "tgl");
    chk("seq.2c", pin_out, 8'h2C);

    cyc(1'b1, 1'b1, 4'd1, 8'h3C, 8'h00, "rw_same");
    chk("rw_same.pre", rdata, 8'hFF);

    cyc(1'b1, 1'b0, 4'd6, 8'h01, 8'h00, "ren");
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h01, "rise_T");
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h01, "rise_T1");
    cyc(1'b0, 1'b1, 4'd2, 8'h00, 8'h01, "rise_T2");
    chk("rise.irq_T2", irq, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h01, "rise_T3");
    chk("rise.in_read", rdata, 8'h01);
    cyc(1'b0, 1'b1, 4'd8, 8'h00, 8'h00, "fall_T");
    chk("rise.stat", rdata, 8'h01);
    repeat (4) cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, "fall_wait");
    cyc(1'b1, 1'b0, 4'd8, 8'h01, 8'h00, "w1c");
    chk("w1c.irq", irq, 1'b0);

    cyc(1'b1, 1'b0, 4'd8, 8'h00, 8'h00, "prep");
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h01, "race_T");
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h01, "race_T1");
    cyc(1'b1, 1'b0, 4'd8, 8'h01, 8'h01, "race_W1C");
    chk("race.irq", irq, 1'b1);
    cyc(1'b0, 1'b1, 4'd8, 8'h00, 8'h01, "race_rd");
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h01, "race_rd1");
    chk("race.stat", rdata, 8'h01);
    cyc(1'b1, 1'b0, 4'd8, 8'h01, 8'h01, "w1c_alone");
    chk("w1c_alone.irq", irq, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 3) == 0, $urandom % 2, 4'($urandom % 16),
          8'($urandom), 8'($urandom), "rand");
    end

    cyc(1'b1, 1'b0, 4'd0, 8'h55, 8'h00, "pre_rst_out");
    cyc(1'b1, 1'b0, 4'd6, 8'h01, 8'h01, "pre_rst_ren");
    repeat (3) cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h01, "pre_rst_edge");
    chk("pre_rst.irq", irq, 1'b1);
    chk("pre_rst.out", pin_out, 8'h55);
    rd_en = 1; addr = 4'd0;
    #2 reset_n = 0;
    #1;
    chk("midrst.pin_out", pin_out, 8'h00);
    chk("midrst.irq", irq, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst.rd_valid", rd_valid, 1'b0);
    model_reset();
    check_all("midrst");
    @(negedge clk);
    reset_n = 1; rd_en = 0;
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, "post_rst");
    chk("post_rst.rd_valid", rd_valid, 1'b0);

    for (int i = 0; i < 200; i++) begin
      cyc(($urandom % 3) == 0, $urandom % 2, 4'($urandom % 16),
          8'($urandom), 8'($urandom), "rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
